// File: rtl/ro_adc_readout_if.sv
// Handshake, ADC and sample-stream signals between the readout stage and its surroundings.
// master = readout stage, slave = exposure FSM / ADC / downstream FIFO side.
interface ro_adc_readout_if #(
    parameter int C_ADC_W = 12
);
    logic               FSMIND1;
    logic               FSMIND1ACK;
    logic               FSMIND0;
    logic               FSMIND0ACK;
    logic [7:0]         ROW_SEL;
    logic               ROW_EN;
    logic [4:0]         COL_SEL;
    logic               ADC_START;
    logic               ADC_DONE;
    logic [C_ADC_W-1:0] ADC_DATA;
    logic [C_ADC_W-1:0] DOUT;
    logic               DOUT_VALID;
    logic               DOUT_READY;
    logic               DOUT_LAST;
    logic               ERR_TIMEOUT;
    logic [31:0]        FRAME_CNT;
    logic [7:0]         fsm_stat;

    modport master (
        input  FSMIND1, FSMIND0ACK, ADC_DONE, ADC_DATA, DOUT_READY,
        output FSMIND1ACK, FSMIND0, ROW_SEL, ROW_EN, COL_SEL, ADC_START,
               DOUT, DOUT_VALID, DOUT_LAST, ERR_TIMEOUT, FRAME_CNT, fsm_stat
    );

    modport slave (
        output FSMIND1, FSMIND0ACK, ADC_DONE, ADC_DATA, DOUT_READY,
        input  FSMIND1ACK, FSMIND0, ROW_SEL, ROW_EN, COL_SEL, ADC_START,
               DOUT, DOUT_VALID, DOUT_LAST, ERR_TIMEOUT, FRAME_CNT, fsm_stat
    );
endinterface

// File: rtl/ro_adc_readout.sv
// Imager readout stage: scans rows x column groups, triggers one ADC conversion per group
// and streams each result on a valid/ready port, bracketed by the exposure-FSM handshakes.
module ro_adc_readout #(
    parameter int C_NUM_ROWS    = 160,
    parameter int C_NUM_COLS    = 18,
    parameter int C_ADC_W       = 12,
    parameter int C_SETTLE      = 8,
    parameter int C_ADC_TIMEOUT = 1024
) (
    input  logic            CLK_HS,
    input  logic            RESET,
    ro_adc_readout_if.master bus
);

    // State codes double as the fsm_stat value, so the status port is the state register itself.
    typedef enum logic [7:0] {
        S_IDLE   = 8'h01,
        S_SETTLE = 8'h02,
        S_CONV   = 8'h04,
        S_WAIT   = 8'h08,
        S_PUSH   = 8'h10,
        S_DONE   = 8'h20
    } state_t;

    state_t             state;
    logic               fsmind1_m, fsmind1_s;
    logic               ack0_m, ack0_s;
    logic [15:0]        settle_cnt;
    logic [15:0]        tmo_cnt;
    logic [7:0]         row_sel;
    logic [4:0]         col_sel;
    logic               row_en;
    logic               adc_start;
    logic [C_ADC_W-1:0] dout;
    logic               dout_valid;
    logic               dout_last;
    logic               err_timeout;
    logic               fsmind1ack;
    logic               fsmind0;
    logic [31:0]        frame_cnt;

    always_ff @(posedge CLK_HS or posedge RESET) begin
        if (RESET) begin
            fsmind1_m <= 1'b0;
            fsmind1_s <= 1'b0;
            ack0_m    <= 1'b0;
            ack0_s    <= 1'b0;
        end else begin
            fsmind1_m <= bus.FSMIND1;
            fsmind1_s <= fsmind1_m;
            ack0_m    <= bus.FSMIND0ACK;
            ack0_s    <= ack0_m;
        end
    end

    always_ff @(posedge CLK_HS or posedge RESET) begin
        if (RESET) begin
            state       <= S_IDLE;
            settle_cnt  <= '0;
            tmo_cnt     <= '0;
            row_sel     <= '0;
            col_sel     <= '0;
            row_en      <= 1'b0;
            adc_start   <= 1'b0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            dout_last   <= 1'b0;
            err_timeout <= 1'b0;
            fsmind1ack  <= 1'b0;
            fsmind0     <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            adc_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A still-high FSMIND0ACK belongs to the previous frame; wait for it to clear.
                    if (fsmind1_s && !ack0_s) begin
                        fsmind1ack <= 1'b1;
                        row_en     <= 1'b1;
                        row_sel    <= '0;
                        col_sel    <= '0;
                        settle_cnt <= '0;
                        state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == 16'(C_SETTLE - 1)) begin
                        state <= S_CONV;
                    end else begin
                        settle_cnt <= settle_cnt + 16'd1;
                    end
                end
                S_CONV: begin
                    adc_start <= 1'b1;
                    tmo_cnt   <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    // A conversion result arriving on the timeout cycle still takes priority.
                    if (bus.ADC_DONE) begin
                        dout       <= bus.ADC_DATA;
                        dout_valid <= 1'b1;
                        dout_last  <= (row_sel == 8'(C_NUM_ROWS - 1)) && (col_sel == 5'(C_NUM_COLS - 1));
                        state      <= S_PUSH;
                    end else if (tmo_cnt == 16'(C_ADC_TIMEOUT - 1)) begin
                        dout        <= '1;
                        err_timeout <= 1'b1;
                        dout_valid  <= 1'b1;
                        dout_last   <= (row_sel == 8'(C_NUM_ROWS - 1)) && (col_sel == 5'(C_NUM_COLS - 1));
                        state       <= S_PUSH;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_PUSH: begin
                    if (bus.DOUT_READY) begin
                        dout_valid <= 1'b0;
                        dout_last  <= 1'b0;
                        if (col_sel < 5'(C_NUM_COLS - 1)) begin
                            col_sel <= col_sel + 5'd1;
                            state   <= S_CONV;
                        end else if (row_sel < 8'(C_NUM_ROWS - 1)) begin
                            row_sel    <= row_sel + 8'd1;
                            col_sel    <= '0;
                            settle_cnt <= '0;
                            state      <= S_SETTLE;
                        end else begin
                            row_en  <= 1'b0;
                            fsmind0 <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (ack0_s) begin
                        fsmind0    <= 1'b0;
                        fsmind1ack <= 1'b0;
                        frame_cnt  <= frame_cnt + 32'd1;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    row_en     <= 1'b0;
                    dout_valid <= 1'b0;
                    dout_last  <= 1'b0;
                    fsmind0    <= 1'b0;
                    fsmind1ack <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.FSMIND1ACK  = fsmind1ack;
    assign bus.FSMIND0     = fsmind0;
    assign bus.ROW_SEL     = row_sel;
    assign bus.ROW_EN      = row_en;
    assign bus.COL_SEL     = col_sel;
    assign bus.ADC_START   = adc_start;
    assign bus.DOUT        = dout;
    assign bus.DOUT_VALID  = dout_valid;
    assign bus.DOUT_LAST   = dout_last;
    assign bus.ERR_TIMEOUT = err_timeout;
    assign bus.FRAME_CNT   = frame_cnt;
    assign bus.fsm_stat    = state;

endmodule
